// File: rtl/nibble_add_sequencer.sv
// Multi-precision adder: one shared 4-bit slice, one nibble per clock, LSB first.
// Optional subtract mode is enabled by defining ADD_SEQ_SUB_EN (adds the sub port).

module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding nibble r_idx, carry rippling through r_carry
// DONE  | result held with out_valid high until consumer takes it
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [3:0]      w_slice_a;
  logic [3:0]      w_slice_b;
  logic [3:0]      w_slice_sum;
  logic            w_slice_cout;
  logic [W-1:0]    w_b_cap;
  logic            w_carry_cap;

  assign w_slice_a = r_a[4*r_idx +: 4];
  assign w_slice_b = r_b[4*r_idx +: 4];

  four_bit_adder u_slice (
    .a    (w_slice_a),
    .b    (w_slice_b),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // Subtract is a + ~b + 1; cout then reads as "no borrow".
`ifdef ADD_SEQ_SUB_EN
  assign w_b_cap     = sub ? ~b : b;
  assign w_carry_cap = sub ? 1'b1 : cin;
`else
  assign w_b_cap     = b;
  assign w_carry_cap = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= w_b_cap;
            r_carry    <= w_carry_cap;
            r_sum      <= '0;
            r_idx      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_sum[4*r_idx +: 4] <= w_slice_sum;
          r_carry             <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_slice_cout;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench for nibble_add_sequencer: directed cases plus random ops
// compared against a plain-arithmetic reference {cout,sum} = a + b + cin.

module tb_nibble_add_sequencer;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_add_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stall: cycles out_ready stays low in DONE; hold_iv keeps in_valid high meanwhile
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input int stall, input logic hold_iv);
    logic [W:0]   exp;
    logic [W-1:0] held_sum;
    logic         held_cout;
    int n;
    if (ts) exp = {1'b0, ta} + {1'b0, ~tb_} + (W+1)'(1);
    else    exp = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    out_ready = (stall == 0);
    tick();
    if (!hold_iv) in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_in_ready", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("latency", n, NIBBLES);
    chk("sum", {16'd0, sum}, {16'd0, exp[W-1:0]});
    chk("cout", {31'd0, cout}, {31'd0, exp[W]});
    held_sum = sum;
    held_cout = cout;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_sum", {16'd0, sum}, {16'd0, held_sum});
      chk("stall_cout", {31'd0, cout}, {31'd0, held_cout});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sum"}, {16'd0, sum}, 32'd0);
    chk({tag, "_cout"}, {31'd0, cout}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_op(16'h0004, 16'h0008, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'h0006, 16'h0003, 1'b1, 1'b0, 3, 1'b1);

    // abort during the second RUN clock
    a = 16'h8F8F; b = 16'h7171; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);

`ifdef ADD_SEQ_SUB_EN
    run_op(16'h0009, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h0001, 16'h0002, 1'b0, 1'b1, 0, 1'b0);
`endif

    for (int k = 0; k < 30; k++) begin
      logic rs;
`ifdef ADD_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), rs,
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
